// File: rtl/vm_ctrl_fsm.sv
// rtl/vm_ctrl_fsm.sv - vending-machine credit/vend/change controller; optional idle refund via VM_TIMEOUT_EN
module vm_ctrl_fsm #(
  parameter int PRICE       = 120,
  parameter int MAX_CREDIT  = 300,
  parameter int CRED_W      = 9
`ifdef VM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_valid,
  input  logic [1:0]        coin_type,
  input  logic              select,
  input  logic              cancel,
  input  logic              chg_ack,
  output logic [CRED_W-1:0] credit,
  output logic              coin_reject,
  output logic              vend,
  output logic              chg_req,
  output logic [1:0]        chg_coin,
  output logic              busy,
  output logic              refund_to
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t            state, state_d;
  logic [CRED_W-1:0] credit_d;
  logic [CRED_W:0]   coin_sum;
  logic              coin_fits;
  logic              coin_reject_d, vend_d, chg_req_d, busy_d, refund_to_d;
  logic [1:0]        chg_coin_d;

`ifdef VM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt, idle_cnt_d;
`endif

  function automatic logic [CRED_W-1:0] coin_val(input logic [1:0] t);
    case (t)
      2'b00:   coin_val = CRED_W'(10);
      2'b01:   coin_val = CRED_W'(20);
      2'b10:   coin_val = CRED_W'(50);
      default: coin_val = CRED_W'(100);
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit.
  function automatic logic [1:0] greedy(input logic [CRED_W-1:0] c);
    if (c >= CRED_W'(100))     greedy = 2'b11;
    else if (c >= CRED_W'(50)) greedy = 2'b10;
    else if (c >= CRED_W'(20)) greedy = 2'b01;
    else                       greedy = 2'b00;
  endfunction

  // One bit wider than credit so a coin on top of a full register cannot wrap.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_val(coin_type)};
  assign coin_fits = (coin_sum <= (CRED_W+1)'(MAX_CREDIT));

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d       = state;
    credit_d      = credit;
    coin_reject_d = 1'b0;
    vend_d        = 1'b0;
    chg_req_d     = chg_req;
    chg_coin_d    = chg_coin;
    refund_to_d   = 1'b0;
`ifdef VM_TIMEOUT_EN
    idle_cnt_d    = '0;
`endif
    case (state)
      IDLE: begin
        chg_req_d  = 1'b0;
        chg_coin_d = 2'b00;
        if (coin_valid) begin
          credit_d = coin_val(coin_type);
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d       = CHANGE;
          chg_req_d     = 1'b1;
          chg_coin_d    = greedy(credit);
          coin_reject_d = coin_valid;
        end else if (select && (credit >= CRED_W'(PRICE))) begin
          state_d       = VEND;
          vend_d        = 1'b1;
          credit_d      = credit - CRED_W'(PRICE);
          coin_reject_d = coin_valid;
        end else begin
          if (coin_valid) begin
            if (coin_fits) credit_d = coin_sum[CRED_W-1:0];
            else           coin_reject_d = 1'b1;
          end
`ifdef VM_TIMEOUT_EN
          // A rejected coin does not count as activity.
          if (!(coin_valid && coin_fits)) begin
            if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state_d     = CHANGE;
              refund_to_d = 1'b1;
              chg_req_d   = 1'b1;
              chg_coin_d  = greedy(credit);
            end else begin
              idle_cnt_d = idle_cnt + 1'b1;
            end
          end
`endif
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        if (credit != '0) begin
          state_d    = CHANGE;
          chg_req_d  = 1'b1;
          chg_coin_d = greedy(credit);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        coin_reject_d = coin_valid;
        if (chg_req) begin
          if (chg_ack) begin
            credit_d  = credit - coin_val(chg_coin);
            chg_req_d = 1'b0;
            if (credit_d == '0) begin
              state_d    = IDLE;
              chg_coin_d = 2'b00;
            end
          end
        end else begin
          chg_req_d  = 1'b1;
          chg_coin_d = greedy(credit);
        end
      end
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and registered outputs; reset discards credit and any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      vend        <= 1'b0;
      chg_req     <= 1'b0;
      chg_coin    <= 2'b00;
      busy        <= 1'b0;
      refund_to   <= 1'b0;
    end else begin
      state       <= state_d;
      credit      <= credit_d;
      coin_reject <= coin_reject_d;
      vend        <= vend_d;
      chg_req     <= chg_req_d;
      chg_coin    <= chg_coin_d;
      busy        <= busy_d;
      refund_to   <= refund_to_d;
    end
  end

`ifdef VM_TIMEOUT_EN
  // Idle counter for the COLLECT auto-refund.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_cnt_d;
  end
`endif

endmodule

// File: tb/tb_vm_ctrl_fsm.sv
// tb/tb_vm_ctrl_fsm.sv - directed table-driven bench for vm_ctrl_fsm
module tb_vm_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, select, cancel, chg_ack;
  logic [1:0] coin_type;
  logic [8:0] credit;
  logic       coin_reject, vend, chg_req, busy, refund_to;
  logic [1:0] chg_coin;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef VM_TIMEOUT_EN
  vm_ctrl_fsm #(.PRICE(120), .MAX_CREDIT(300), .CRED_W(9), .TIMEOUT_CYC(16)) dut (
`else
  vm_ctrl_fsm #(.PRICE(120), .MAX_CREDIT(300), .CRED_W(9)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .select(select), .cancel(cancel), .chg_ack(chg_ack), .credit(credit),
    .coin_reject(coin_reject), .vend(vend), .chg_req(chg_req),
    .chg_coin(chg_coin), .busy(busy), .refund_to(refund_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       sel;
    logic       can;
    logic       ack;
    int         e_credit;
    logic       e_rej;
    logic       e_vend;
    logic       e_req;
    logic [1:0] e_coin;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [1:0] ct, input logic sel, input logic can,
                     input logic ack, input int cr, input logic rej, input logic vd,
                     input logic req, input logic [1:0] cn, input logic bz);
    vec_t v;
    v = '{cv, ct, sel, can, ack, cr, rej, vd, req, cn, bz};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0; cancel = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t; tick(); clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // credit, rej, vend, req, coin, busy
    add(1,3,0,0,0, 100,0,0,0,0,0);
    add(1,2,0,0,0, 150,0,0,0,0,0);
    add(0,0,1,0,0,  30,0,1,0,0,1);
    add(0,0,0,0,0,  30,0,0,1,1,1);
    add(0,0,0,0,1,  10,0,0,0,1,1);
    add(0,0,0,0,0,  10,0,0,1,0,1);
    add(0,0,0,0,1,   0,0,0,0,0,0);
    add(0,0,1,1,0,   0,0,0,0,0,0);
    add(1,3,0,0,0, 100,0,0,0,0,0);
    add(0,0,1,0,0, 100,0,0,0,0,0);
    add(0,0,0,1,0, 100,0,0,1,3,1);
    add(0,0,0,0,1,   0,0,0,0,0,0);
    add(1,3,0,0,0, 100,0,0,0,0,0);
    add(1,3,0,0,0, 200,0,0,0,0,0);
    add(1,3,0,0,0, 300,0,0,0,0,0);
    add(1,0,0,0,0, 300,1,0,0,0,0);
    add(1,2,1,0,0, 180,1,1,0,0,1);
    add(0,0,0,0,0, 180,0,0,1,3,1);
    add(1,0,0,0,0, 180,1,0,1,3,1);
    add(0,0,0,0,1,  80,0,0,0,3,1);
    add(0,0,0,0,1,  80,0,0,1,2,1);
    add(0,0,0,0,1,  30,0,0,0,2,1);
    add(0,0,0,0,0,  30,0,0,1,1,1);
    add(0,0,0,0,1,  10,0,0,0,1,1);
    add(0,0,0,0,0,  10,0,0,1,0,1);
    add(0,0,0,0,1,   0,0,0,0,0,0);
    add(1,0,0,0,0,  10,0,0,0,0,0);
    add(1,1,0,1,0,  10,1,0,1,0,1);
    add(0,0,0,0,1,   0,0,0,0,0,0);
    add(1,3,0,0,0, 100,0,0,0,0,0);
    add(1,1,0,0,0, 120,0,0,0,0,0);
    add(0,0,1,0,0,   0,0,1,0,0,1);
    add(0,0,0,0,0,   0,0,0,0,0,0);
    add(1,2,0,0,0,  50,0,0,0,0,0);
    add(1,3,1,0,0, 150,0,0,0,0,0);
    add(0,0,0,1,0, 150,0,0,1,3,1);
    add(0,0,0,0,1,  50,0,0,0,3,1);
    add(0,0,0,0,0,  50,0,0,1,2,1);
    add(0,0,0,0,1,   0,0,0,0,0,0);

    clear_in();
    rst_n = 1'b0;
    tick(); tick();
    check("reset_outputs", int'({credit, coin_reject, vend, chg_req, chg_coin, busy, refund_to}), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      coin_valid = vecs[i].cv; coin_type = vecs[i].ct; select = vecs[i].sel;
      cancel = vecs[i].can; chg_ack = vecs[i].ack;
      tick();
      clear_in();
      check($sformatf("vec%0d", i),
            int'({credit, coin_reject, vend, chg_req, chg_coin, busy, refund_to}),
            int'({9'(vecs[i].e_credit), vecs[i].e_rej, vecs[i].e_vend, vecs[i].e_req,
                  vecs[i].e_coin, vecs[i].e_busy, 1'b0}));
    end

    // Backpressure: change request held stable while ack stays low.
    coin(2'b11); coin(2'b10);
    select = 1'b1; tick(); clear_in();
    check("bp_vend", int'(vend), 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) coin_valid = 1'b1;
      tick();
      check($sformatf("bp_hold%0d", k), int'({chg_req, chg_coin, credit}), int'({1'b1, 2'b01, 9'd30}));
      if (k == 2) check("bp_coin_reject", int'(coin_reject), 1);
      clear_in();
    end
    chg_ack = 1'b1; tick(); clear_in();
    check("bp_ack1", int'({chg_req, credit}), int'({1'b0, 9'd10}));
    tick();
    check("bp_next_coin", int'({chg_req, chg_coin}), int'({1'b1, 2'b00}));
    chg_ack = 1'b1; tick(); clear_in();
    check("bp_done", int'({credit, busy, chg_req}), 0);

    // Asynchronous reset in the middle of a change handshake.
    coin(2'b11); coin(2'b11);
    cancel = 1'b1; tick(); clear_in();
    check("rst_pre", int'({chg_req, chg_coin, credit}), int'({1'b1, 2'b11, 9'd200}));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", int'({credit, coin_reject, vend, chg_req, chg_coin, busy, refund_to}), 0);
    #3;
    rst_n = 1'b1;
    tick();
    chg_ack = 1'b1; select = 1'b1; cancel = 1'b1; tick(); clear_in();
    check("rst_idle_ignores", int'({credit, chg_req, busy, vend}), 0);
    coin(2'b01);
    check("rst_idle_coin", int'(credit), 20);

`ifdef VM_TIMEOUT_EN
    cancel = 1'b1; tick(); clear_in();
    chg_ack = 1'b1; tick(); clear_in();
    check("to_clean", int'({credit, busy}), 0);
    coin(2'b10);
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("to_wait%0d", k), int'({refund_to, busy}), 0);
    end
    tick();
    check("to_fire", int'({refund_to, chg_req, chg_coin, busy, credit}),
          int'({1'b1, 1'b1, 2'b10, 1'b1, 9'd50}));
    tick();
    check("to_pulse_end", int'(refund_to), 0);
    chg_ack = 1'b1; tick(); clear_in();
    check("to_idle", int'({credit, busy, chg_req}), 0);
`else
    for (int k = 0; k < 40; k++) tick();
    check("no_timeout", int'({refund_to, busy, chg_req, credit}), int'({3'b000, 9'd20}));
    cancel = 1'b1; tick(); clear_in();
    check("no_to_cancel", int'({chg_req, chg_coin}), int'({1'b1, 2'b01}));
    chg_ack = 1'b1; tick(); clear_in();
    check("no_to_idle", int'({credit, busy}), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
